// File: rtl/core_id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, backpressure and flush.
// Optional event counters are built when CORE_ID_EX_STATS_EN is defined.
module core_id_ex_stage #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic              id_reg_write,
   input  logic              id_alu_src,
   input  logic              id_mem_to_reg,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_alu_src,
   output logic              ex_mem_to_reg,
`ifdef CORE_ID_EX_STATS_EN
   output logic [31:0]       stat_bubbles,
   output logic [31:0]       stat_flushes,
`endif
   output logic              load_use_stall
);

   logic              valid_q, valid_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
   logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
   logic [XLEN-1:0]   imm_q, imm_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              reg_write_q, reg_write_d;
   logic              alu_src_q, alu_src_d;
   logic              mem_to_reg_q, mem_to_reg_d;

   logic advance;
   logic hazard;
   logic rd_match;

   assign advance = !valid_q || ex_ready;

   // rs2 only matters for R-type; I-type and loads take the immediate instead.
   assign rd_match = (id_rs1 == rd_q) || (!id_alu_src && (id_rs2 == rd_q));
   assign hazard   = valid_q && mem_to_reg_q && (rd_q != '0) && id_valid && rd_match;

   assign load_use_stall = hazard;
   assign id_ready       = advance && !hazard && !flush;

   always_comb begin
      valid_d      = valid_q;
      pc_d         = pc_q;
      rs1_data_d   = rs1_data_q;
      rs2_data_d   = rs2_data_q;
      imm_d        = imm_q;
      rd_d         = rd_q;
      reg_write_d  = reg_write_q;
      alu_src_d    = alu_src_q;
      mem_to_reg_d = mem_to_reg_q;
      if (flush) begin
         valid_d      = 1'b0;
         reg_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
      end else if (advance) begin
         if (id_valid && !hazard) begin
            valid_d      = 1'b1;
            pc_d         = id_pc;
            rs1_data_d   = id_rs1_data;
            rs2_data_d   = id_rs2_data;
            imm_d        = id_imm;
            rd_d         = id_rd;
            reg_write_d  = id_reg_write;
            alu_src_d    = id_alu_src;
            mem_to_reg_d = id_mem_to_reg;
         end else begin
            // Bubble: payload held, side-effecting controls cleared.
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         pc_q         <= '0;
         rs1_data_q   <= '0;
         rs2_data_q   <= '0;
         imm_q        <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         alu_src_q    <= 1'b0;
         mem_to_reg_q <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         pc_q         <= pc_d;
         rs1_data_q   <= rs1_data_d;
         rs2_data_q   <= rs2_data_d;
         imm_q        <= imm_d;
         rd_q         <= rd_d;
         reg_write_q  <= reg_write_d;
         alu_src_q    <= alu_src_d;
         mem_to_reg_q <= mem_to_reg_d;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_pc         = pc_q;
   assign ex_rs1_data   = rs1_data_q;
   assign ex_rs2_data   = rs2_data_q;
   assign ex_imm        = imm_q;
   assign ex_rd         = rd_q;
   assign ex_reg_write  = reg_write_q;
   assign ex_alu_src    = alu_src_q;
   assign ex_mem_to_reg = mem_to_reg_q;

`ifdef CORE_ID_EX_STATS_EN
   logic [31:0] bubbles_q, bubbles_d;
   logic [31:0] flushes_q, flushes_d;

   always_comb begin
      bubbles_d = bubbles_q;
      flushes_d = flushes_q;
      if (flush) begin
         flushes_d = flushes_q + 32'd1;
      end else if (advance && hazard) begin
         bubbles_d = bubbles_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubbles_q <= '0;
         flushes_q <= '0;
      end else begin
         bubbles_q <= bubbles_d;
         flushes_q <= flushes_d;
      end
   end

   assign stat_bubbles = bubbles_q;
   assign stat_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_core_id_ex_stage.sv
// Bench for core_id_ex_stage: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model of the held entry.
module tb_core_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, flush, id_valid, id_ready, ex_valid, ex_ready, load_use_stall;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_reg_write, id_alu_src, id_mem_to_reg;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_alu_src, ex_mem_to_reg;
`ifdef CORE_ID_EX_STATS_EN
   logic [31:0] stat_bubbles, stat_flushes;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   bit          chk_en   = 1'b0;

   always #5 clk = ~clk;

   core_id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_reg_write(id_reg_write), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src),
      .ex_mem_to_reg(ex_mem_to_reg),
`ifdef CORE_ID_EX_STATS_EN
      .stat_bubbles(stat_bubbles), .stat_flushes(stat_flushes),
`endif
      .load_use_stall(load_use_stall)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the stage is a one-entry slot holding either an instruction or nothing.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rd;
      logic        rw, alu, m2r;
   } ent_t;

   ent_t        m;
   logic [31:0] m_bub, m_fl;

   function automatic logic model_hazard();
      logic uses_rd;
      uses_rd = (id_rs1 == m.rd) || (id_alu_src == 1'b0 && id_rs2 == m.rd);
      return m.valid && m.m2r && m.rd != 5'd0 && id_valid && uses_rd;
   endfunction

   function automatic logic model_slot_free();
      return !m.valid || ex_ready;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m     <= '0;
         m_bub <= '0;
         m_fl  <= '0;
      end else if (flush) begin
         m.valid <= 1'b0;
         m.rw    <= 1'b0;
         m.m2r   <= 1'b0;
         m_fl    <= m_fl + 32'd1;
      end else if (model_slot_free()) begin
         if (id_valid && !model_hazard()) begin
            m <= '{1'b1, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rd,
                   id_reg_write, id_alu_src, id_mem_to_reg};
         end else begin
            m.valid <= 1'b0;
            m.rw    <= 1'b0;
            m.m2r   <= 1'b0;
            if (model_hazard()) m_bub <= m_bub + 32'd1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_ex_valid", 32'(ex_valid), 32'(m.valid));
         chk("m_ex_pc", ex_pc, m.pc);
         chk("m_ex_rs1_data", ex_rs1_data, m.rs1d);
         chk("m_ex_rs2_data", ex_rs2_data, m.rs2d);
         chk("m_ex_imm", ex_imm, m.imm);
         chk("m_ex_rd", 32'(ex_rd), 32'(m.rd));
         chk("m_ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
         chk("m_ex_alu_src", 32'(ex_alu_src), 32'(m.alu));
         chk("m_ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m.m2r));
         chk("m_load_use_stall", 32'(load_use_stall), 32'(model_hazard()));
         chk("m_id_ready", 32'(id_ready),
             32'(model_slot_free() && !model_hazard() && !flush));
`ifdef CORE_ID_EX_STATS_EN
         chk("m_stat_bubbles", stat_bubbles, m_bub);
         chk("m_stat_flushes", stat_flushes, m_fl);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic alu,
                         input logic m2r, input logic rw);
      id_valid      = v;
      id_pc         = pc;
      id_rs1        = rs1;
      id_rs2        = rs2;
      id_rd         = rd;
      id_alu_src    = alu;
      id_mem_to_reg = m2r;
      id_reg_write  = rw;
      id_rs1_data   = $urandom;
      id_rs2_data   = $urandom;
      id_imm        = $urandom;
   endtask

   initial begin
      rst      = 1'b1;
      flush    = 1'b0;
      ex_ready = 1'b1;
      set_id(1'b1, 32'h50, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1);
      step();
      chk_en = 1'b1;
      step();
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_ex_pc", ex_pc, 32'd0);
      chk("rst_ex_imm", ex_imm, 32'd0);
      chk("rst_ex_rd", 32'(ex_rd), 32'd0);
      chk("rst_ex_mem_to_reg", 32'(ex_mem_to_reg), 32'd0);

      rst = 1'b0;
      set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
      #1 chk("post_rst_id_ready", 32'(id_ready), 32'd1);
      step();
      chk("stream0_valid", 32'(ex_valid), 32'd1);
      chk("stream0_pc", ex_pc, 32'h100);
      chk("stream0_alu_src", 32'(ex_alu_src), 32'd0);
      set_id(1'b1, 32'h104, 5'd4, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1);
      step();
      chk("stream1_valid", 32'(ex_valid), 32'd1);
      chk("stream1_pc", ex_pc, 32'h104);
      chk("stream1_alu_src", 32'(ex_alu_src), 32'd1);

      // Load rd=5 followed by R-type reading rs2=5.
      set_id(1'b1, 32'h108, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
      step();
      set_id(1'b1, 32'h10C, 5'd2, 5'd5, 5'd6, 1'b0, 1'b0, 1'b1);
      #1;
      chk("lu_stall", 32'(load_use_stall), 32'd1);
      chk("lu_id_ready", 32'(id_ready), 32'd0);
      step();
      chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
      chk("lu_bubble_m2r", 32'(ex_mem_to_reg), 32'd0);
      #1;
      chk("lu_after_stall", 32'(load_use_stall), 32'd0);
      chk("lu_after_ready", 32'(id_ready), 32'd1);
      step();
      chk("lu_capture_pc", ex_pc, 32'h10C);

      // alu_src=1: rs2 match is ignored.
      set_id(1'b1, 32'h110, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
      step();
      set_id(1'b1, 32'h114, 5'd2, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1);
      #1 chk("imm_no_stall", 32'(load_use_stall), 32'd0);
      step();
      chk("imm_capture_pc", ex_pc, 32'h114);

      // Load with rd=0 never stalls.
      set_id(1'b1, 32'h118, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      step();
      set_id(1'b1, 32'h11C, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
      #1 chk("rd0_no_stall", 32'(load_use_stall), 32'd0);
      step();
      chk("rd0_capture_pc", ex_pc, 32'h11C);

      // Backpressure.
      set_id(1'b1, 32'h200, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
      step();
      ex_ready = 1'b0;
      set_id(1'b1, 32'h204, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_id_ready", 32'(id_ready), 32'd0);
         step();
         chk("bp_hold_pc", ex_pc, 32'h200);
         chk("bp_hold_valid", 32'(ex_valid), 32'd1);
      end
      ex_ready = 1'b1;
      #1 chk("bp_release_ready", 32'(id_ready), 32'd1);
      step();
      chk("bp_next_pc", ex_pc, 32'h204);
      id_valid = 1'b0;
      step();
      chk("bp_no_dup", 32'(ex_valid), 32'd0);

      // Flush a held load under backpressure.
      set_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1);
      step();
      ex_ready = 1'b0;
      flush    = 1'b1;
      set_id(1'b1, 32'h304, 5'd1, 5'd2, 5'd8, 1'b0, 1'b0, 1'b1);
      #1 chk("fl_id_ready", 32'(id_ready), 32'd0);
      step();
      chk("fl_valid", 32'(ex_valid), 32'd0);
      chk("fl_m2r", 32'(ex_mem_to_reg), 32'd0);
      chk("fl_rw", 32'(ex_reg_write), 32'd0);
      chk("fl_pc_held", ex_pc, 32'h300);
      flush    = 1'b0;
      ex_ready = 1'b1;
      #1 chk("fl_retry_ready", 32'(id_ready), 32'd1);
      step();
      chk("fl_retry_pc", ex_pc, 32'h304);

      // Randomized traffic; small register space makes hazards frequent.
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 199) == 0);
         flush    = ($urandom_range(0, 19) == 0);
         ex_ready = ($urandom_range(0, 9) < 7);
         set_id(($urandom_range(0, 9) < 8), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
         step();
      end

      rst   = 1'b0;
      flush = 1'b0;
      step();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
